// File: rtl/pipe_ctrl.sv
// Pipeline hazard and halt controller.
// Drives stage write enables and bubbles, drains the pipe on HALT.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_stall,
  input  logic        imem_stall,
  input  logic        load_use,
  input  logic        branch_taken,
  input  logic        halt_id,
  output logic        pc_wen,
  output logic        ifid_wen,
  output logic        idex_wen,
  output logic        exmem_wen,
  output logic        memwb_wen,
  output logic        ifid_bubble,
  output logic        idex_bubble,
  output logic        memwb_bubble,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] drain_cnt;
  logic       stall_inc;
  logic       halt_go;

  // Hazard resolution: enables and bubbles from state and hazard inputs
  always_comb begin
    pc_wen       = 1'b0;
    ifid_wen     = 1'b0;
    idex_wen     = 1'b0;
    exmem_wen    = 1'b0;
    memwb_wen    = 1'b0;
    ifid_bubble  = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    stall_inc    = 1'b0;
    halt_go      = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          pc_wen    = 1'b1;
          ifid_wen  = 1'b1;
          idex_wen  = 1'b1;
          exmem_wen = 1'b1;
          memwb_wen = 1'b1;
          priority case (1'b1)
            dmem_stall: begin
              pc_wen       = 1'b0;
              ifid_wen     = 1'b0;
              idex_wen     = 1'b0;
              exmem_wen    = 1'b0;
              memwb_bubble = 1'b1;
              stall_inc    = 1'b1;
            end
            branch_taken: begin
              ifid_bubble = 1'b1;
              idex_bubble = 1'b1;
            end
            load_use: begin
              pc_wen      = 1'b0;
              ifid_wen    = 1'b0;
              idex_bubble = 1'b1;
              stall_inc   = 1'b1;
            end
            imem_stall: begin
              pc_wen      = 1'b0;
              ifid_bubble = 1'b1;
              stall_inc   = 1'b1;
            end
            halt_id: begin
              pc_wen      = 1'b0;
              ifid_bubble = 1'b1;
              halt_go     = 1'b1;
            end
            default: ;
          endcase
        end
        DRAIN: begin
          ifid_bubble = 1'b1;
          memwb_wen   = 1'b1;
          if (dmem_stall) begin
            memwb_bubble = 1'b1;
            stall_inc    = 1'b1;
          end else begin
            ifid_wen  = 1'b1;
            idex_wen  = 1'b1;
            exmem_wen = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control FSM with drain counter, halted flag and stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
      halted    <= 1'b0;
      stall_cnt <= 16'h0000;
    end else begin
      if (stall_inc && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      unique case (state)
        RUN: begin
          if (halt_go) begin
            state     <= DRAIN;
            drain_cnt <= 2'd3;
          end
        end
        DRAIN: begin
          if (!dmem_stall) begin
            drain_cnt <= drain_cnt - 2'd1;
            if (drain_cnt == 2'd1) begin
              state  <= HALTED;
              halted <= 1'b1;
            end
          end
        end
        HALTED: halted <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl.
// Hazard priority, halt drain, reset abort and counter saturation.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dmem_stall = 1'b0;
  logic        imem_stall = 1'b0;
  logic        load_use = 1'b0;
  logic        branch_taken = 1'b0;
  logic        halt_id = 1'b0;
  logic        pc_wen;
  logic        ifid_wen;
  logic        idex_wen;
  logic        exmem_wen;
  logic        memwb_wen;
  logic        ifid_bubble;
  logic        idex_bubble;
  logic        memwb_bubble;
  logic        halted;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail = 0;

  logic [4:0] wen;
  logic [2:0] bub;
  assign wen = {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen};
  assign bub = {ifid_bubble, idex_bubble, memwb_bubble};

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .dmem_stall   (dmem_stall),
    .imem_stall   (imem_stall),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .halt_id      (halt_id),
    .pc_wen       (pc_wen),
    .ifid_wen     (ifid_wen),
    .idex_wen     (idex_wen),
    .exmem_wen    (exmem_wen),
    .memwb_wen    (memwb_wen),
    .ifid_bubble  (ifid_bubble),
    .idex_bubble  (idex_bubble),
    .memwb_bubble (memwb_bubble),
    .halted       (halted),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [4:0] w,
                      input logic [2:0] b);
    #1;
    chk({tag, "_wen"}, {11'd0, wen}, {11'd0, w});
    chk({tag, "_bub"}, {13'd0, bub}, {13'd0, b});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic d, input logic i, input logic l,
                       input logic b, input logic h);
    dmem_stall   = d;
    imem_stall   = i;
    load_use     = l;
    branch_taken = b;
    halt_id      = h;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_cnt", stall_cnt, 16'h0000);
    chk("rst_wen", {11'd0, wen}, 16'd0);
    chk("rst_bub", {13'd0, bub}, 16'd0);
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #1;
    drive(0, 0, 0, 0, 0);
    do_reset();

    outs("idle", 5'b11111, 3'b000);
    cyc();

    drive(0, 0, 1, 0, 0);
    outs("lu", 5'b00111, 3'b010);
    cyc();
    chk("lu_cnt", stall_cnt, 16'd1);

    drive(0, 0, 1, 1, 0);
    outs("br_lu", 5'b11111, 3'b110);
    cyc();
    chk("br_lu_cnt", stall_cnt, 16'd1);

    drive(0, 1, 0, 0, 0);
    outs("imem", 5'b01111, 3'b100);
    cyc();
    chk("imem_cnt", stall_cnt, 16'd2);

    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 1, 0);
      outs("dm_br", 5'b00001, 3'b001);
      cyc();
    end
    chk("dm_br_cnt", stall_cnt, 16'd5);
    drive(0, 0, 0, 1, 0);
    outs("br_after", 5'b11111, 3'b110);
    cyc();
    chk("br_after_cnt", stall_cnt, 16'd5);

    drive(0, 1, 1, 0, 0);
    outs("lu_im", 5'b00111, 3'b010);
    cyc();
    chk("lu_im_cnt", stall_cnt, 16'd6);

    drive(0, 0, 0, 0, 1);
    outs("halt_t", 5'b01111, 3'b100);
    cyc();
    drive(0, 0, 0, 0, 0);
    outs("drain1", 5'b01111, 3'b100);
    chk("drain1_h", {15'd0, halted}, 16'd0);
    cyc();
    drive(0, 1, 1, 1, 1);
    outs("drain2", 5'b01111, 3'b100);
    cyc();
    drive(0, 0, 0, 0, 0);
    outs("drain3", 5'b01111, 3'b100);
    chk("drain3_h", {15'd0, halted}, 16'd0);
    cyc();
    chk("halt_h", {15'd0, halted}, 16'd1);
    drive(1, 1, 1, 1, 1);
    outs("halt_out", 5'b00000, 3'b000);
    cyc();
    chk("halt_cnt", stall_cnt, 16'd6);
    chk("halt_hold", {15'd0, halted}, 16'd1);

    drive(0, 0, 0, 0, 0);
    do_reset();

    drive(0, 0, 0, 0, 1);
    cyc();
    drive(0, 0, 0, 0, 0);
    cyc();
    drive(1, 0, 0, 0, 0);
    outs("ds_drain", 5'b00001, 3'b101);
    cyc();
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("ds_cnt", stall_cnt, 16'd2);
    cyc();
    chk("ds_t5_h", {15'd0, halted}, 16'd0);
    outs("ds_t5", 5'b01111, 3'b100);
    cyc();
    chk("ds_t6_h", {15'd0, halted}, 16'd1);

    do_reset();
    drive(0, 0, 0, 0, 1);
    cyc();
    drive(1, 0, 0, 0, 0);
    cyc();
    chk("md_cnt", stall_cnt, 16'd1);
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("md_rst_cnt", stall_cnt, 16'd0);
    chk("md_rst_h", {15'd0, halted}, 16'd0);
    chk("md_rst_wen", {11'd0, wen}, 16'd0);
    rst = 1'b0;
    outs("md_run", 5'b11111, 3'b000);
    cyc();
    outs("md_run2", 5'b11111, 3'b000);

    drive(0, 1, 0, 0, 0);
    repeat (65534) cyc();
    chk("sat_pre", stall_cnt, 16'hFFFE);
    cyc();
    chk("sat_1", stall_cnt, 16'hFFFF);
    cyc();
    chk("sat_2", stall_cnt, 16'hFFFF);
    outs("sat_out", 5'b01111, 3'b100);
    cyc();
    chk("sat_hold", stall_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: dmem_stall  in  1  data memory busy; MEM-stage access not complete this cycle.
REQ-004 SHALL have: imem_stall  in  1  instruction memory busy; fetch not complete this cycle.
REQ-005 SHALL have: load_use  in  1  ID-stage instruction needs the result of a load in EX.
REQ-006 SHALL have: branch_taken  in  1  EX-stage control transfer redirects the PC this cycle.
REQ-007 SHALL have: halt_id  in  1  HALT decoded in ID.
REQ-008 SHALL have outputs pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen  out  1 each  write enables for PC and the four pipeline registers.
REQ-009 SHALL have outputs ifid_bubble, idex_bubble, memwb_bubble  out  1 each  force the inval bit into IF/ID, ID/EX and MEM/WB on write.
REQ-010 SHALL have: halted  out  1  registered; processor stopped.
REQ-011 SHALL have: stall_cnt  out  16  registered saturating count of stall cycles.

Function
REQ-012 SHALL implement FSM states RUN, DRAIN, HALTED with a 2-bit drain counter.
REQ-013 Write-enable and bubble outputs SHALL be combinational from state and inputs; halted and stall_cnt SHALL be registered.
REQ-014 In RUN, rules SHALL apply in priority order P1..P6; unlisted wen = 1, unlisted bubble = 0.
REQ-015 P1 dmem_stall: pc/ifid/idex/exmem wen = 0; memwb_wen = 1; memwb_bubble = 1; all other inputs ignored.
REQ-016 P2 branch_taken: all wen = 1; ifid_bubble = 1; idex_bubble = 1; load_use, imem_stall and halt_id ignored.
REQ-017 P3 load_use: pc_wen = 0; ifid_wen = 0; idex_bubble = 1.
REQ-018 P4 imem_stall: pc_wen = 0; ifid_bubble = 1.
REQ-019 P5 halt_id: pc_wen = 0; ifid_bubble = 1; HALT advances to ID/EX; next state DRAIN with drain counter = 3.
REQ-020 P6 none active: all wen = 1, no bubbles.
REQ-021 In DRAIN: pc_wen = 0 and ifid_bubble = 1 every cycle; load_use, imem_stall, branch_taken and halt_id are ignored.
REQ-022 In DRAIN with dmem_stall = 1: the P1 freeze pattern SHALL apply, with pc_wen = 0; the drain counter SHALL hold.
REQ-023 In DRAIN with dmem_stall = 0: the drain counter SHALL decrement; at counter = 1, next state SHALL be HALTED.
REQ-024 In HALTED: all wen = 0; all bubbles = 0; halted = 1; no exit except rst.
REQ-025 stall_cnt SHALL increment on each cycle in RUN where P1, P3 or P4 is selected, and on each DRAIN cycle with dmem_stall = 1.
REQ-026 stall_cnt SHALL saturate at 0xFFFF, with no wrap.
REQ-027 stall_cnt SHALL not count HALTED cycles or P5 cycles.

Reset
REQ-028 rst = 1 SHALL immediately, without waiting for clk, set state = RUN, drain counter = 0, halted = 0 and stall_cnt = 0x0000.
REQ-029 While rst = 1, all wen and bubble outputs SHALL be 0.
REQ-030 rst asserted in any state, including mid-DRAIN or mid-stall, SHALL abort the operation in progress.
REQ-031 The first edge after rst deasserts SHALL evaluate RUN rules.

Verification
REQ-032 Load-use stall: load_use = 1 for 1 cycle in RUN -> pc_wen = 0, ifid_wen = 0, idex_bubble = 1, exmem/memwb wen = 1; stall_cnt 0 -> 1.
REQ-033 Branch over load-use: branch_taken = 1 and load_use = 1 together -> all wen = 1, ifid_bubble = idex_bubble = 1; stall_cnt unchanged.
REQ-034 Data stall over branch: dmem_stall = 1 for 3 cycles with branch_taken = 1 -> upper wen = 0 and memwb_bubble = 1 for 3 cycles; stall_cnt += 3; branch honoured on cycle 4.
REQ-035 Halt sequence: halt_id pulse at cycle t with no stalls -> DRAIN during t+1..t+3, HALTED and halted = 1 from t+4, all wen = 0 thereafter.
REQ-036 Halt with data stall: dmem_stall = 1 for 2 cycles at t+2 -> halted rises at t+6.
REQ-037 Halt with mid-DRAIN reset: rst pulse mid-DRAIN -> RUN and stall_cnt = 0 immediately.
REQ-038 Saturation: stall_cnt preloaded to 0xFFFE via 65534 imem_stall cycles, then 2 more stall cycles -> stall_cnt = 0xFFFF and holds.
